// File: rtl/uart_tx_scheduler.sv
// Round-robin write arbiter feeding a shared TX FIFO, plus a drain FSM that
// pops one byte at a time into the UART transmitter.
module uart_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_data_in,
    input  logic                       fifo_full,
    output logic                       fifo_rd_en,
    input  logic [WIDTH-1:0]           fifo_data_out,
    input  logic                       fifo_empty,
    output logic                       tx_start,
    output logic [WIDTH-1:0]           tx_data,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       sched_busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RDWAIT = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_TXWAIT = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_grant;
    logic [WIDTH-1:0] r_tx_data;
    logic             r_tx_start;
    logic             r_busy;
    logic             w_found;
    logic [IDW-1:0]   w_winner;
    logic             w_rd_en;
    logic             w_accept;

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        return (sum >= NUM_REQ) ? IDW'(sum - NUM_REQ) : IDW'(sum);
    endfunction

    // Round-robin search for the first valid requester starting at the pointer
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[rr_index(r_ptr, k)]) begin
                w_found  = 1'b1;
                w_winner = rr_index(r_ptr, k);
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Reset gating keeps every strobe quiet from the instant reset asserts; pop beats push
    assign w_rd_en      = (r_state == S_IDLE) & ~fifo_empty & ~tx_busy & ~reset;
    assign w_accept     = w_found & ~fifo_full & ~w_rd_en & ~reset;
    assign req_ready    = w_accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner) : '0;
    assign fifo_wr_en   = w_accept;
    assign fifo_data_in = req_data[w_winner*WIDTH +: WIDTH];
    assign fifo_rd_en   = w_rd_en;

    // Drain FSM next-state decode
    always_comb begin
        case (r_state)
            S_IDLE:   w_next = w_rd_en ? S_RDWAIT : S_IDLE;
            S_RDWAIT: w_next = S_LOAD;
            S_LOAD:   w_next = S_START;
            S_START:  w_next = S_TXWAIT;
            S_TXWAIT: w_next = tx_done ? S_IDLE : S_TXWAIT;
            default:  w_next = S_IDLE;
        endcase
    end

    // Drain FSM state and registered transmitter-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_tx_start <= (w_next == S_START);
            r_busy     <= (w_next != S_IDLE);
            if (r_state == S_LOAD) begin
                r_tx_data <= fifo_data_out;
            end else begin
                r_tx_data <= r_tx_data;
            end
        end
    end

    // Round-robin pointer and last-grant register advance only on an accepted push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_grant <= '0;
        end else if (w_accept) begin
            r_ptr   <= (w_winner == LAST_ID) ? '0 : w_winner + 1'b1;
            r_grant <= w_winner;
        end else begin
            r_ptr   <= r_ptr;
            r_grant <= r_grant;
        end
    end

    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign grant_id   = r_grant;
    assign sched_busy = r_busy;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with behavioural FIFO and transmitter
// models; expected pushes, bytes and launch times come from a reference model.
module tb_uart_tx_scheduler;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full = 1'b0;
    logic           fifo_rd_en;
    logic [W-1:0]   fifo_data_out = '0;
    logic           fifo_empty = 1'b1;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;
    logic [1:0]     grant_id;
    logic           sched_busy;

    uart_tx_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in), .fifo_full(fifo_full),
        .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
        .grant_id(grant_id), .sched_busy(sched_busy)
    );

    logic [W-1:0] fq[$];
    logic [W-1:0] exp_push_q[$];
    logic [W-1:0] exp_tx_q[$];
    int           exp_start_q[$];
    int  checks = 0, errors = 0, cyc = 0;
    int  m_ptr = 0, m_grant = 0, tx_cnt = 0;
    bit  m_inflight = 1'b0, last_rd = 1'b0, last_wr = 1'b0, rst_req = 1'b1;
    logic [W-1:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: update environment, drive stimulus, predict and check combinational behaviour
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input bit xbusy, input bit stray, input int len);
        bit p_rd, p_wr, found;
        int w, idx;
        @(negedge clk);
        cyc++;
        if (!reset) begin
            chk("grant_id", 32'(grant_id), 32'(m_grant));
            chk("sched_busy", 32'(sched_busy), 32'(m_inflight));
        end
        if (last_rd && fq.size() > 0) fifo_data_out = fq.pop_front();
        if (last_wr && fq.size() < DEPTH) fq.push_back(last_data);
        fifo_full  = (fq.size() == DEPTH);
        fifo_empty = (fq.size() == 0);
        tx_done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_done = 1'b1;
        end
        if (tx_start) tx_cnt = len;
        if (stray && tx_cnt == 0 && !m_inflight && !tx_done) tx_done = 1'b1;
        reset = rst_req;
        if (reset) begin
            tx_cnt = 0;
            tx_done = 1'b0;
        end
        tx_busy   = xbusy | (tx_cnt > 0);
        req_valid = v;
        req_data  = d;
        #1;
        if (reset) begin
            m_ptr = 0; m_grant = 0; m_inflight = 1'b0;
            exp_push_q.delete();
            exp_start_q.delete();
            exp_tx_q = fq;
            chk("rst_tx_start", 32'(tx_start), 32'd0);
            chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_grant", 32'(grant_id), 32'd0);
            chk("rst_tx_data", 32'(tx_data), 32'd0);
            chk("rst_busy", 32'(sched_busy), 32'd0);
        end else begin
            p_rd  = !m_inflight && !fifo_empty && !tx_busy;
            found = 1'b0;
            w     = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && v[idx]) begin
                    found = 1'b1;
                    w = idx;
                end
            end
            p_wr = found && !fifo_full && !p_rd;
            chk("fifo_rd_en", 32'(fifo_rd_en), 32'(p_rd));
            chk("fifo_wr_en", 32'(fifo_wr_en), 32'(p_wr));
            chk("req_ready", 32'(req_ready), p_wr ? (32'd1 << w) : 32'd0);
            chk("wr_rd_exclusive", 32'(fifo_wr_en & fifo_rd_en), 32'd0);
            if (p_wr) begin
                exp_push_q.push_back(d[w*W +: W]);
                exp_tx_q.push_back(d[w*W +: W]);
                m_ptr   = (w + 1) % N;
                m_grant = w;
            end
            if (p_rd) begin
                exp_start_q.push_back(cyc + 3);
                m_inflight = 1'b1;
            end else if (tx_done && m_inflight) begin
                m_inflight = 1'b0;
            end
        end
        last_rd   = fifo_rd_en;
        last_wr   = fifo_wr_en;
        last_data = fifo_data_in;
    endtask

    // Monitor: compare every DUT push and every transmitter launch with the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (fifo_wr_en) begin
                    if (exp_push_q.size() == 0) chk("unexpected_push", 32'd1, 32'd0);
                    else chk("push_data", 32'(fifo_data_in), 32'(exp_push_q.pop_front()));
                end
                if (tx_start) begin
                    if (exp_tx_q.size() == 0) chk("unexpected_tx_byte", 32'd1, 32'd0);
                    else chk("tx_data", 32'(tx_data), 32'(exp_tx_q.pop_front()));
                    if (exp_start_q.size() == 0) chk("unexpected_tx_start", 32'd1, 32'd0);
                    else chk("tx_start_cycle", 32'(cyc), 32'(exp_start_q.pop_front()));
                end
            end
        end
    end

    task automatic drain(input int len);
        int n;
        n = 0;
        while ((fq.size() != 0 || m_inflight || tx_cnt != 0 || last_wr || last_rd) && n < 3000) begin
            step('0, '0, 1'b0, 1'b0, len);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    localparam logic [N*W-1:0] FIXED = {8'h40, 8'h30, 8'h20, 8'h10};

    initial begin
        int n;
        rst_req = 1'b1;
        repeat (3) step('0, '0, 1'b0, 1'b0, 4);
        rst_req = 1'b0;

        // All requesters valid, transmitter busy: rotating pushes until FIFO full
        repeat (24) step(4'hF, FIXED, 1'b1, 1'b0, 10);
        chk("fifo_filled", 32'(fq.size()), 32'(DEPTH));
        // Release transmitter: pops resume, pushes refill after each pop
        repeat (60) step(4'hF, FIXED, 1'b0, 1'b0, 10);
        drain(10);

        // Only requester 2: first push moves pointer to 3, second must wrap to 2
        repeat (4) step(4'b0100, {$urandom}, 1'b1, 1'b0, 5);
        drain(5);

        // Single byte 0xA5, transmitter completes 10 cycles after launch
        step(4'b0001, {24'h0, 8'hA5}, 1'b0, 1'b0, 10);
        drain(10);

        // Randomized traffic with stray completion pulses
        for (int i = 0; i < 1000; i++)
            step(N'($urandom), {$urandom}, ($urandom_range(9) == 0), ($urandom_range(15) == 0),
                 int'($urandom_range(6, 1)));
        drain(3);

        // Reset mid-transmission with bytes still queued
        n = 0;
        while (!(m_inflight && exp_start_q.size() == 0 && tx_cnt > 2 && fq.size() >= 3) && n < 500) begin
            step(4'hF, {$urandom}, 1'b0, 1'b0, 8);
            n++;
        end
        if (n >= 500) chk("reset_setup_timeout", 32'd1, 32'd0);
        rst_req = 1'b1;
        repeat (12) step(N'($urandom), {$urandom}, 1'b0, 1'b0, 4);
        rst_req = 1'b0;
        drain(4);

        repeat (3) step('0, '0, 1'b0, 1'b0, 4);
        chk("push_q_empty", 32'(exp_push_q.size()), 32'd0);
        chk("tx_q_empty", 32'(exp_tx_q.size()), 32'd0);
        chk("start_q_empty", 32'(exp_start_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
